// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the instruction fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int                     INSTR_WIDTH    = 32;
    localparam logic [INSTR_WIDTH-1:0] INSTR_NOP_HALT = 32'h0000_0000;
    localparam logic [31:0]            PC_STEP        = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_controller_pc_register.sv
`default_nettype none
// ============================================================================
// Module      : pc_register
// Description : Program counter with reset/init, branch redirect, sequential
//               advance and an out-of-range flag for the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_register
    import riscv_pkg::*;
#(
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        advance_i,
    output logic [31:0] pc_o,
    output logic        out_of_range_o
);

    localparam logic [31:0] c_PC_LIMIT = 32'(MEM_WORDS * 4);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: init beats redirect beats advance; otherwise hold (covers stall).
    always_comb begin
        pc_d = pc_q;
        if (init_i) begin
            pc_d = RESET_PC;
        end else if (redirect_i) begin
            pc_d = target_i & ~32'h3;
        end else if (advance_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o           = pc_q;
    assign out_of_range_o = (pc_q >= c_PC_LIMIT);

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Instruction fetch sequencer. Arbitrates the instruction memory
//               between boot-time loading and execution fetch, tracks the
//               one-cycle read in flight and presents fetched words with a
//               valid flag. Handles stall, branch redirect and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller
    import riscv_pkg::*;
#(
    parameter int          MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                  load_data,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    output logic [31:0]                  mem_wdata,
    output logic [31:0]                  mem_raddr,
    input  logic [31:0]                  mem_rdata,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [31:0]                  branch_target,
    output logic [31:0]                  instr,
    output logic [31:0]                  instr_pc,
    output logic                         instr_valid,
    output logic                         halted
);

    fetch_state_t state_q, state_d;

    logic                   inflight_q, inflight_d;
    logic [31:0]            inflight_pc_q, inflight_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [31:0]            instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    // The memory keeps re-reading the PC during a stall, which overwrites the
    // word that was in flight. That word is parked here on the first stalled
    // edge and used in place of mem_rdata when the stall releases.
    logic [INSTR_WIDTH-1:0] hold_q, hold_d;
    logic                   held_q, held_d;

    logic                   pc_init;
    logic                   pc_redirect;
    logic                   pc_advance;
    logic [31:0]            pc;
    logic                   pc_out_of_range;
    logic [INSTR_WIDTH-1:0] fetched;

    pc_register #(
        .MEM_WORDS (MEM_WORDS),
        .RESET_PC  (RESET_PC)
    ) u_pc_register (
        .clk_i          (clock),
        .rst_ni         (reset),
        .init_i         (pc_init),
        .redirect_i     (pc_redirect),
        .target_i       (branch_target),
        .advance_i      (pc_advance),
        .pc_o           (pc),
        .out_of_range_o (pc_out_of_range)
    );

    assign fetched = held_q ? hold_q : mem_rdata;

    // Next-state, in-flight tracking and output-register update.
    always_comb begin
        state_d       = state_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        hold_d        = hold_q;
        held_d        = held_q;
        pc_init       = 1'b0;
        pc_redirect   = 1'b0;
        pc_advance    = 1'b0;

        case (state_q)
            IDLE: begin
                instr_valid_d = 1'b0;
                inflight_d    = 1'b0;
                held_d        = 1'b0;
                // A simultaneous load wins; start is dropped that cycle.
                if (start && !load_valid) begin
                    state_d = RUN;
                    pc_init = 1'b1;
                end
            end

            RUN: begin
                if (branch_taken) begin
                    pc_redirect   = 1'b1;
                    inflight_d    = 1'b0;
                    instr_valid_d = 1'b0;
                    held_d        = 1'b0;
                end else if (stall) begin
                    if (inflight_q && !held_q) begin
                        hold_d = mem_rdata;
                        held_d = 1'b1;
                    end
                end else begin
                    held_d = 1'b0;
                    if (inflight_q && (fetched == INSTR_NOP_HALT)) begin
                        state_d       = HALT;
                        instr_valid_d = 1'b0;
                        inflight_d    = 1'b0;
                    end else begin
                        if (inflight_q) begin
                            instr_d       = fetched;
                            instr_pc_d    = inflight_pc_q;
                            instr_valid_d = 1'b1;
                        end else begin
                            instr_valid_d = 1'b0;
                        end
                        // An out-of-range PC issues nothing; the last in-range
                        // word still drains before entering HALT.
                        if (pc_out_of_range) begin
                            inflight_d = 1'b0;
                            if (!inflight_q) begin
                                state_d = HALT;
                            end
                        end else begin
                            pc_advance    = 1'b1;
                            inflight_d    = 1'b1;
                            inflight_pc_d = pc;
                        end
                    end
                end
            end

            HALT: begin
                instr_valid_d = 1'b0;
                inflight_d    = 1'b0;
                held_d        = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, in-flight and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            instr_q       <= '0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            hold_q        <= '0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            hold_q        <= hold_d;
            held_q        <= held_d;
        end
    end

    // Loader owns the write port only in IDLE and never while reset is held.
    assign load_ready  = reset && (state_q == IDLE);
    assign mem_we      = load_ready && load_valid;
    assign mem_waddr   = load_addr;
    assign mem_wdata   = load_data;
    assign mem_raddr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign halted      = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Self-checking bench for fetch_controller: vector table,
//               directed corner sequences and a randomized stream check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam int MW = 32;

    logic        clk = 1'b0;
    logic        reset, start, load_valid, stall, branch_taken;
    logic [4:0]  load_addr;
    logic [31:0] load_data, branch_target;
    logic        load_ready, mem_we, instr_valid, halted;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata, mem_raddr, instr, instr_pc;
    logic [31:0] mem_rdata;

    logic [31:0] imem    [MW];
    logic [31:0] ref_mem [MW];
    int          checks = 0;
    int          errors = 0;
    int          oob_reads = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    int          consumed;

    always #5 clk = ~clk;

    fetch_controller #(.MEM_WORDS(MW), .RESET_PC(32'h0)) dut (
        .clock(clk), .reset(reset), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .halted(halted)
    );

    // Instruction memory: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) imem[mem_waddr] <= mem_wdata;
        mem_rdata <= (mem_raddr < 32'd128) ? imem[mem_raddr[6:2]] : 32'hBAD0_0001;
        if (mem_raddr > 32'd128) oob_reads <= oob_reads + 1;
    end

    typedef struct {
        logic rst, st, lv;
        logic [4:0] la;
        logic [31:0] ld;
        logic rdy, we, vld;
        logic [31:0] ipc, ins;
        logic hlt;
        logic [31:0] ra;
    } vec_t;

    function automatic vec_t v(input logic rst, st, lv, input logic [4:0] la,
                               input logic [31:0] ld, input logic rdy, we, vld,
                               input logic [31:0] ipc, ins, input logic hlt,
                               input logic [31:0] ra);
        vec_t r;
        r.rst = rst; r.st = st; r.lv = lv; r.la = la; r.ld = ld;
        r.rdy = rdy; r.we = we; r.vld = vld; r.ipc = ipc; r.ins = ins;
        r.hlt = hlt; r.ra = ra;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; load_valid = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; load_addr = '0; load_data = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_valid = 1'b1; load_addr = a[4:0]; load_data = d;
        #1;
        check("load_we", {31'b0, mem_we}, 32'd1);
        check("load_ready", {31'b0, load_ready}, 32'd1);
        @(negedge clk);
        load_valid = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_pc = 32'h0; consumed = 0; last_pc = 32'hFFFF_FFFF;
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference rule: every word presented with stall low is consumed once, in
    // program order from the last redirect target, and must equal the loaded word.
    task automatic run_cycle(input logic stl, input logic br, input logic [31:0] tgt);
        stall = stl; branch_taken = br; branch_target = tgt;
        #1;
        if (instr_valid && !stl) begin
            check("stream_pc", instr_pc, exp_pc);
            check("stream_word", instr, ref_mem[exp_pc[6:2]]);
            last_pc = instr_pc;
            exp_pc  = exp_pc + 32'd4;
            consumed++;
        end
        if (halted) check("halt_no_valid", {31'b0, instr_valid}, 32'd0);
        if (br) exp_pc = tgt & ~32'h3;
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
    endtask

    vec_t vecs [15];
    logic ok;
    logic [31:0] w;
    int zero_at;

    initial begin
        // Load, run, halt on zero word, reset, start+load arbitration.
        vecs[0]  = v(1,0,1,5'd0,32'h001080B3, 1,1,0,0,0,0,0);
        vecs[1]  = v(1,0,1,5'd1,32'h00208133, 1,1,0,0,0,0,0);
        vecs[2]  = v(1,0,1,5'd2,32'h00000000, 1,1,0,0,0,0,0);
        vecs[3]  = v(1,1,0,5'd0,32'h0,        1,0,0,0,0,0,0);
        vecs[4]  = v(1,0,0,5'd0,32'h0,        0,0,0,0,0,0,0);
        vecs[5]  = v(1,0,0,5'd0,32'h0,        0,0,0,0,0,0,4);
        vecs[6]  = v(1,0,0,5'd0,32'h0,        0,0,1,0,32'h001080B3,0,8);
        vecs[7]  = v(1,0,0,5'd0,32'h0,        0,0,1,4,32'h00208133,0,12);
        vecs[8]  = v(1,1,0,5'd0,32'h0,        0,0,0,0,0,1,12);
        vecs[9]  = v(1,0,0,5'd0,32'h0,        0,0,0,0,0,1,12);
        vecs[10] = v(0,0,0,5'd0,32'h0,        0,0,0,0,0,1,12);
        vecs[11] = v(1,1,1,5'd3,32'hDEADBEEF, 1,1,0,0,0,0,0);
        vecs[12] = v(1,0,0,5'd0,32'h0,        1,0,0,0,0,0,0);
        vecs[13] = v(1,1,0,5'd0,32'h0,        1,0,0,0,0,0,0);
        vecs[14] = v(1,0,0,5'd0,32'h0,        0,0,0,0,0,0,0);

        do_reset();
        #1;
        check("rst_load_ready", {31'b0, load_ready}, 32'd1);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_raddr", mem_raddr, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst; start = vecs[i].st; load_valid = vecs[i].lv;
            load_addr = vecs[i].la; load_data = vecs[i].ld;
            #1;
            check($sformatf("vec%0d_ready", i), {31'b0, load_ready}, {31'b0, vecs[i].rdy});
            check($sformatf("vec%0d_we", i), {31'b0, mem_we}, {31'b0, vecs[i].we});
            check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].vld});
            check($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vecs[i].hlt});
            check($sformatf("vec%0d_raddr", i), mem_raddr, vecs[i].ra);
            if (vecs[i].vld) begin
                check($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].ipc);
                check($sformatf("vec%0d_instr", i), instr, vecs[i].ins);
            end
            if (vecs[i].we) begin
                check($sformatf("vec%0d_waddr", i), {27'b0, mem_waddr}, {27'b0, vecs[i].la});
                check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].ld);
            end
            @(negedge clk);
        end
        start = 1'b0; load_valid = 1'b0;

        // Stall hold: full straight-line program, stall 3 cycles at instr_pc=4.
        do_reset();
        for (int k = 0; k < MW; k++) load_word(k, 32'h0010_0013 + 32'(k) * 32'h100);
        start_run();
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1;
            if (instr_valid && instr_pc == 32'd4) ok = 1'b1;
            else @(negedge clk);
        end
        check("stall_reach", {31'b0, ok}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            stall = 1'b1;
            #1;
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_pc", instr_pc, 32'd4);
            check("stall_word", instr, ref_mem[1]);
            check("stall_raddr", mem_raddr, 32'd12);
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        check("release_pc", instr_pc, 32'd4);
        @(negedge clk);
        #1;
        check("after_stall_valid", {31'b0, instr_valid}, 32'd1);
        check("after_stall_pc", instr_pc, 32'd8);
        check("after_stall_word", instr, ref_mem[2]);

        // Branch flush, then branch together with stall.
        do_reset();
        start_run();
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            #1;
            if (mem_raddr == 32'd8) ok = 1'b1;
            else @(negedge clk);
        end
        check("branch_reach", {31'b0, ok}, 32'd1);
        branch_taken = 1'b1; branch_target = 32'h0000_000E;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("flush_valid", {31'b0, instr_valid}, 32'd0);
        wait_valid(ok);
        check("branch_arrive", {31'b0, ok}, 32'd1);
        check("branch_pc", instr_pc, 32'd12);
        check("branch_word", instr, ref_mem[3]);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0040;
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0;
        #1;
        check("flush2_valid", {31'b0, instr_valid}, 32'd0);
        wait_valid(ok);
        check("branch2_arrive", {31'b0, ok}, 32'd1);
        check("branch2_pc", instr_pc, 32'h40);
        check("branch2_word", instr, ref_mem[16]);

        // Boundary run to end of memory, with a load attempt during RUN.
        do_reset();
        start_run();
        load_valid = 1'b1; load_addr = 5'd20; load_data = 32'h0;
        #1;
        check("run_load_ready", {31'b0, load_ready}, 32'd0);
        check("run_mem_we", {31'b0, mem_we}, 32'd0);
        run_cycle(1'b0, 1'b0, 32'h0);
        load_valid = 1'b0;
        for (int c = 0; c < 200 && !halted; c++) run_cycle(1'b0, 1'b0, 32'h0);
        #1;
        check("bound_halted", {31'b0, halted}, 32'd1);
        check("bound_last_pc", last_pc, 32'd124);
        check("bound_count", 32'(consumed), 32'd32);
        check("bound_raddr", mem_raddr, 32'd128);
        @(negedge clk);
        #1;
        check("bound_raddr_hold", mem_raddr, 32'd128);

        // Reset in the middle of a fetch.
        do_reset();
        start_run();
        wait_valid(ok);
        check("mid_reach", {31'b0, ok}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_instr", instr, 32'h0);
        check("mid_instr_pc", instr_pc, 32'h0);
        check("mid_halted", {31'b0, halted}, 32'd0);
        check("mid_load_ready", {31'b0, load_ready}, 32'd1);
        check("mid_raddr", mem_raddr, 32'h0);
        @(negedge clk);
        start_run();
        #1;
        check("refetch_v0", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("refetch_v1", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("refetch_valid", {31'b0, instr_valid}, 32'd1);
        check("refetch_pc", instr_pc, 32'h0);
        check("refetch_word", instr, ref_mem[0]);

        // Randomized programs with random stalls and redirects.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            zero_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1;
            for (int k = 0; k < MW; k++) begin
                w = $urandom | 32'h1;
                if (k == zero_at) w = 32'h0;
                load_word(k, w);
            end
            start_run();
            for (int c = 0; c < 1500; c++) begin
                #1;
                if (halted) break;
                run_cycle($urandom_range(0, 99) < 30,
                          (c < 150) && ($urandom_range(0, 99) < 4),
                          32'($urandom_range(0, 127)));
            end
            #1;
            check("rand_halted", {31'b0, halted}, 32'd1);
            check("rand_halt_reason",
                  (exp_pc >= 32'd128) ? 32'd1 : {31'b0, ref_mem[exp_pc[6:2]] == 32'h0},
                  32'd1);
            @(negedge clk);
        end

        check("no_read_beyond", 32'(oob_reads), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
